pc_fetch_unit: RTL and testbench

Instruction fetch controller that consumes the program counter's `pc` output and drives the counter's `nextPC`/`enable` inputs, closing the PC loop. It issues one instruction-memory read per PC value using a request/grant plus response-valid protocol, and presents the fetched word to decode with a valid/ready handshake. It also takes branch redirects from execute and flushes in-flight fetches. It sits between the ProgramCounter register and the decode stage.

---
 rtl/pc_fetch_unit.sv | 111 +++++++++++
 tb/tb_pc_fetch_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction fetch controller closing the ProgramCounter loop: one imem read per PC,
// fetched word handed to decode, branch redirects flush whatever is in flight.
module pc_fetch_unit #(
    parameter logic [31:0] PC_STEP = 32'd4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        pc_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        fault,
    output logic [2:0]  fsm_state
);

    // Handshakes: imem read is issued on the cycle imem_req && imem_gnt; data returns on
    // imem_rvalid while waiting; decode takes instr on the cycle instr_valid && instr_ready.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT   = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t state;
    logic   kill;
    logic   pc_aligned;
    logic   target_aligned;

    assign pc_aligned     = (pc[1:0] == 2'b00);
    assign target_aligned = (redirect_pc[1:0] == 2'b00);

    assign next_pc   = redirect ? redirect_pc : (pc + PC_STEP);
    assign pc_en     = redirect | ((state == S_OUT) & instr_ready);
    // A redirect withdraws a pending request unless the grant lands the same cycle.
    assign imem_req  = (state == S_REQ) & pc_aligned & (~redirect | imem_gnt);
    assign imem_addr = pc;
    assign fsm_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            kill        <= 1'b0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_REQ;
                end
                S_REQ: begin
                    if (redirect) begin
                        if (imem_gnt && pc_aligned) begin
                            kill  <= 1'b1;
                            state <= S_WAIT;
                        end
                    end else if (!pc_aligned) begin
                        fault <= 1'b1;
                        state <= S_FAULT;
                    end else if (imem_gnt) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        kill <= 1'b0;
                        if (!kill && !redirect) begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            state       <= S_OUT;
                        end else begin
                            state <= S_REQ;
                        end
                    end else if (redirect) begin
                        kill <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (redirect || instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= S_REQ;
                    end
                end
                S_FAULT: begin
                    if (redirect && target_aligned) begin
                        fault <= 1'b0;
                        state <= S_REQ;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: a ProgramCounter register and memory responder around the DUT,
// a transaction-level fetch model checked every cycle, plus directed scenario checks.
module tb_pc_fetch_unit;

    localparam logic [31:0] STEP = 32'd4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        pc_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b1;
    logic        fault;
    logic [2:0]  fsm_state;

    // stimulus controls
    logic        mem_auto = 1'b1;
    logic        fixed_en = 1'b0;
    logic        man_gnt = 1'b0;
    logic        man_rvalid = 1'b0;
    logic [31:0] man_rdata = 32'h0;
    logic        auto_rvalid = 1'b0;
    logic [31:0] auto_rdata = 32'h0;
    logic        force_en = 1'b1;
    logic [31:0] force_val = 32'h0;

    int n_checks = 0;
    int n_pass = 0;

    // model state
    logic        inflight = 1'b0;
    logic        inflight_kill = 1'b0;
    logic [31:0] inflight_pc = 32'h0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_instr = 32'h0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_q[$];
    logic [31:0] gnt_log[$];
    logic [31:0] pcen_log[$];
    logic [31:0] deliv_pc_log[$];
    logic [31:0] deliv_instr_log[$];

    assign imem_gnt    = mem_auto ? 1'b1 : man_gnt;
    assign imem_rvalid = mem_auto ? auto_rvalid : man_rvalid;
    assign imem_rdata  = mem_auto ? auto_rdata : man_rdata;

    pc_fetch_unit #(.PC_STEP(STEP)) dut (
        .clk(clk), .reset_n(reset_n), .pc(pc), .next_pc(next_pc), .pc_en(pc_en),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .instr_ready(instr_ready), .fault(fault), .fsm_state(fsm_state)
    );

    // clock / reset-independent infrastructure
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (force_en) pc <= force_val;
        else if (pc_en) pc <= next_pc;
    end

    // zero-wait memory: rvalid the cycle after a grant
    always begin
        logic        g;
        logic [31:0] ga;
        @(negedge clk);
        g  = mem_auto && reset_n && imem_req && imem_gnt;
        ga = imem_addr;
        @(posedge clk);
        #1;
        auto_rvalid = g;
        auto_rdata  = g ? (fixed_en ? 32'h1234_5678 : (ga ^ 32'hA5A5_0000)) : 32'h0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic wait_for(input string name, input bit want_valid, input int budget);
        int n = 0;
        mid();
        while (!(want_valid ? instr_valid : imem_req) && n < budget) begin
            cyc();
            mid();
            n++;
        end
        chk(name, 32'(want_valid ? instr_valid : imem_req), 32'd1);
    endtask

    task automatic chk_log(input string name, input logic [31:0] log_q[$]);
        foreach (exp_q[i])
            chk(name, (i < log_q.size()) ? log_q[i] : 32'hDEAD_BEEF ^ exp_q[i], exp_q[i]);
    endtask

    // scoreboard: fetch transactions tracked from grant to delivery
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_instr_valid", 32'(instr_valid), 32'd0);
            chk("rst_imem_req", 32'(imem_req), 32'd0);
            chk("rst_pc_en", 32'(pc_en), 32'd0);
            chk("rst_fault", 32'(fault), 32'd0);
            chk("rst_instr", instr, 32'd0);
            chk("rst_instr_pc", instr_pc, 32'd0);
            chk("rst_state", 32'(fsm_state), 32'd0);
            inflight  = 1'b0;
            exp_valid = 1'b0;
        end else begin
            chk("next_pc", next_pc, redirect ? redirect_pc : pc + STEP);
            chk("instr_valid", 32'(instr_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("instr", instr, exp_instr);
                chk("instr_pc", instr_pc, exp_pc);
            end
            chk("pc_en", 32'(pc_en), 32'(redirect | (exp_valid & instr_ready)));
            if (imem_req) begin
                chk("req_addr", imem_addr, pc);
                chk("req_aligned", 32'(imem_addr[1:0]), 32'd0);
                chk("req_single", 32'(inflight | exp_valid), 32'd0);
            end
            if (pc_en) pcen_log.push_back(next_pc);
            if (imem_req && imem_gnt) gnt_log.push_back(imem_addr);
            if (exp_valid && instr_ready && !redirect) begin
                deliv_pc_log.push_back(instr_pc);
                deliv_instr_log.push_back(instr);
            end
            if (exp_valid && (instr_ready || redirect)) exp_valid = 1'b0;
            if (inflight && imem_rvalid) begin
                if (!inflight_kill && !redirect) begin
                    exp_valid = 1'b1;
                    exp_instr = imem_rdata;
                    exp_pc    = inflight_pc;
                end
                inflight = 1'b0;
            end else if (inflight && redirect) begin
                inflight_kill = 1'b1;
            end
            if (imem_req && imem_gnt) begin
                inflight      = 1'b1;
                inflight_pc   = pc;
                inflight_kill = redirect;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // reset and sequential fetch
        #1 reset_n = 1'b0;
        repeat (3) cyc();
        reset_n  = 1'b1;
        force_en = 1'b0;
        mid();
        chk("first_cycle_req", 32'(imem_req), 32'd0);
        cyc();
        mid();
        chk("second_cycle_req", 32'(imem_req), 32'd1);
        chk("second_cycle_addr", imem_addr, 32'h0);
        repeat (9) cyc();
        exp_q = '{32'h0, 32'h4, 32'h8};
        chk_log("seq_gnt_addr", gnt_log);
        chk_log("seq_instr_pc", deliv_pc_log);
        exp_q = '{32'h4, 32'h8, 32'hC};
        chk_log("seq_next_pc", pcen_log);
        exp_q = '{32'hA5A5_0000, 32'hA5A5_0004, 32'hA5A5_0008};
        chk_log("seq_instr", deliv_instr_log);
        chk("seq_pc_en_count", 32'(pcen_log.size()), 32'd3);

        // backpressure
        instr_ready = 1'b0;
        fixed_en    = 1'b1;
        wait_for("bp_valid_timeout", 1'b1, 10);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                cyc();
                mid();
            end
            chk("bp_instr", instr, 32'h1234_5678);
            chk("bp_valid", 32'(instr_valid), 32'd1);
            chk("bp_pc_en", 32'(pc_en), 32'd0);
            chk("bp_req", 32'(imem_req), 32'd0);
        end
        cyc();
        instr_ready = 1'b1;
        mid();
        chk("bp_release_pc_en", 32'(pc_en), 32'd1);
        chk("bp_release_next_pc", next_pc, 32'h10);
        cyc();
        mem_auto = 1'b0;
        man_gnt  = 1'b0;
        mid();
        chk("bp_single_pc_en", 32'(pc_en), 32'd0);
        chk("bp_valid_drop", 32'(instr_valid), 32'd0);

        // redirect during WAIT, response two cycles later is dropped
        wait_for("rw_req_timeout", 1'b0, 10);
        chk("rw_addr", imem_addr, 32'h10);
        cyc(); man_gnt = 1'b1;
        cyc(); man_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
        mid();
        chk("rw_pc_en", 32'(pc_en), 32'd1);
        chk("rw_next_pc", next_pc, 32'h100);
        cyc(); redirect = 1'b0;
        cyc(); man_rvalid = 1'b1; man_rdata = 32'hBADB_AD00;
        cyc(); man_rvalid = 1'b0;
        mid();
        chk("rw_no_valid", 32'(instr_valid), 32'd0);
        chk("rw_req", 32'(imem_req), 32'd1);
        chk("rw_new_addr", imem_addr, 32'h100);

        // redirect together with instr_ready in OUT
        cyc(); man_gnt = 1'b1;
        cyc(); man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hCAFE_0001; instr_ready = 1'b0;
        cyc(); man_rvalid = 1'b0;
        mid();
        chk("ro_valid", 32'(instr_valid), 32'd1);
        chk("ro_instr", instr, 32'hCAFE_0001);
        chk("ro_instr_pc", instr_pc, 32'h100);
        cyc(); redirect = 1'b1; redirect_pc = 32'h200; instr_ready = 1'b1;
        mid();
        chk("ro_pc_en", 32'(pc_en), 32'd1);
        chk("ro_next_pc", next_pc, 32'h200);
        cyc(); redirect = 1'b0; instr_ready = 1'b0;
        mid();
        chk("ro_flushed", 32'(instr_valid), 32'd0);
        chk("ro_no_second_pc_en", 32'(pc_en), 32'd0);
        chk("ro_next_addr", imem_addr, 32'h200);

        // redirect together with gnt in REQ
        cyc(); man_gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
        mid();
        chk("rg_req_issued", 32'(imem_req), 32'd1);
        chk("rg_next_pc", next_pc, 32'h300);
        cyc(); man_gnt = 1'b0; redirect = 1'b0;
        mid();
        chk("rg_wait_no_req", 32'(imem_req), 32'd0);
        cyc(); man_rvalid = 1'b1; man_rdata = 32'hDEAD_DEAD;
        cyc(); man_rvalid = 1'b0;
        mid();
        chk("rg_dropped", 32'(instr_valid), 32'd0);
        chk("rg_req", 32'(imem_req), 32'd1);
        chk("rg_addr", imem_addr, 32'h300);

        // ordinary fetch after the redirects
        cyc(); man_gnt = 1'b1;
        cyc(); man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h0000_0300; instr_ready = 1'b1;
        cyc(); man_rvalid = 1'b0;
        mid();
        chk("nf_valid", 32'(instr_valid), 32'd1);
        chk("nf_instr_pc", instr_pc, 32'h300);
        chk("nf_next_pc", next_pc, 32'h304);

        // misaligned PC raises a sticky fault, aligned redirect clears it
        cyc(); force_en = 1'b1; force_val = 32'h6;
        cyc(); force_en = 1'b0;
        mid();
        chk("mis_no_req", 32'(imem_req), 32'd0);
        cyc();
        mid();
        chk("mis_fault", 32'(fault), 32'd1);
        chk("mis_fault_no_req", 32'(imem_req), 32'd0);
        cyc();
        mid();
        chk("mis_fault_sticky", 32'(fault), 32'd1);
        cyc(); redirect = 1'b1; redirect_pc = 32'h40;
        mid();
        chk("mis_redir_pc_en", 32'(pc_en), 32'd1);
        chk("mis_redir_next_pc", next_pc, 32'h40);
        cyc(); redirect = 1'b0;
        mid();
        chk("mis_fault_cleared", 32'(fault), 32'd0);
        chk("mis_req", 32'(imem_req), 32'd1);
        chk("mis_addr", imem_addr, 32'h40);

        // wrap at the top of the address space
        cyc(); force_en = 1'b1; force_val = 32'hFFFF_FFFC;
        cyc(); force_en = 1'b0;
        mid();
        chk("wrap_next_pc", next_pc, 32'h0);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        cyc(); man_gnt = 1'b1;
        cyc(); man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h0000_0077;
        cyc(); man_rvalid = 1'b0;
        mid();
        chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_pc_en", 32'(pc_en), 32'd1);
        chk("wrap_out_next_pc", next_pc, 32'h0);

        // reset asserted during WAIT, stale response after release ignored
        cyc(); man_gnt = 1'b1;
        cyc(); man_gnt = 1'b0;
        #2;
        reset_n  = 1'b0;
        force_en = 1'b1;
        force_val = 32'h0;
        #1;
        chk("mr_valid_now", 32'(instr_valid), 32'd0);
        chk("mr_req_now", 32'(imem_req), 32'd0);
        cyc();
        cyc();
        reset_n = 1'b1; force_en = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h5555_5555;
        mid();
        chk("mr_stale_no_valid", 32'(instr_valid), 32'd0);
        chk("mr_idle_no_req", 32'(imem_req), 32'd0);
        cyc(); man_rvalid = 1'b0;
        mid();
        chk("mr_req_after", 32'(imem_req), 32'd1);
        chk("mr_addr_after", imem_addr, 32'h0);
        cyc();
        mid();
        chk("mr_still_no_valid", 32'(instr_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
